// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the bit-serial add controller.
//   state_t : controller state encoding (IDLE, SHIFT, DONE), 2 bits
//   cnt_w() : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, the single datapath element reused every cycle by
// serial_adder_ctrl.
// Ports:
//   A, B   : operand bits
//   C_in   : carry in
//   S      : sum bit
//   C_out  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);

    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: processes a WIDTH-bit operand pair one bit per clock,
// LSB first, through a single full_adder cell. {C_out,S} = A + B + C_in.
//
// Parameters:
//   WIDTH  : operand/result width (>= 2)
// Ports:
//   CLK    : clock, rising edge
//   RST    : asynchronous reset, active-high
//   start  : request, sampled only in IDLE or DONE
//   A, B   : operands, captured on accepted start
//   C_in   : initial carry, captured on accepted start
//   SUB    : (only with SERIAL_ADDER_SUB_EN) 1 = compute A - B
//   S      : sum, updated on entry to DONE and held afterwards
//   C_out  : final carry (with SUB: 1 = no borrow)
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when the result has just completed
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds SUB port, subtraction).
// Latency: start sampled at edge k -> done high after edge k+WIDTH.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_c_out;

    logic               w_accept;
    logic               w_last;
    logic               w_sum;
    logic               w_cell_cout;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

    // A new operation may start only when no bits are in flight.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
    // A - B == A + ~B + 1; C_in is ignored when subtracting.
    assign w_b_load = SUB ? ~B : B;
    assign w_c_load = SUB ? 1'b1 : C_in;
`else
    assign w_b_load = B;
    assign w_c_load = C_in;
`endif

    full_adder u_full_adder (
        .A     (r_a_sr[0]),
        .B     (r_b_sr[0]),
        .C_in  (r_carry),
        .S     (w_sum),
        .C_out (w_cell_cout)
    );

    // ---------------------------------------------------------------- state
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path leaves w_next_state unassigned,
        // which would infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next_state = SHIFT;
            SHIFT:   if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = w_accept ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // NOTE: the shift registers, carry and counter are all reset so an
    // interrupted operation leaves no trace once RST is released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_s      <= '0;
            r_c_out  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= A;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            // Sum bits enter at the MSB; after WIDTH shifts bit 0 is the LSB.
            r_res_sr <= {w_sum, r_res_sr[WIDTH-1:1]};
            r_carry  <= w_cell_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // The final sum bit is still on the wire, so publish the
                // shifted value directly rather than r_res_sr.
                r_s     <= {w_sum, r_res_sr[WIDTH-1:1]};
                r_c_out <= w_cell_cout;
            end
        end
    end

    assign S     = r_s;
    assign C_out = r_c_out;

endmodule
